// File: rtl/outport_capture_if.sv
// rtl/outport_capture_if.sv - valid/ready stream carrying captured outport values
interface outport_capture_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  // Capture block drives data/valid, downstream consumer drives ready
  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/outport_capture.sv
// rtl/outport_capture.sv - change-detecting outport sampler feeding a show-ahead FIFO stream (optional OUTPORT_CAP_SYNC_EN input synchronizer)
module outport_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       outport_in,
  input  logic                    en,
  outport_capture_if.master       m_if,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [7:0]              capture_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

  logic [DATA_W-1:0] s;

`ifdef OUTPORT_CAP_SYNC_EN
  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] sync2_q, sync2_d;

  // Two-stage shift of the foreign-clock port value
  always_comb begin
    sync1_d = outport_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = outport_in;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              push_req;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              valid;
  logic              full;
  logic              pop;
  logic              push_ok;

  // Capture FSM: PRIME pushes the current sample once, TRACK pushes on change
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = PRIME;
      end
      PRIME: begin
        if (en) begin
          push_req = 1'b1;
          prev_d   = s;
          state_d  = TRACK;
        end else begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        if (en) begin
          push_req = (s != prev_q);
          prev_d   = s;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when a pop frees the slot
  always_comb begin
    valid      = (level_q != '0);
    full       = (level_q == LW'(DEPTH));
    pop        = valid & m_if.m_ready;
    push_ok    = push_req & (~full | pop);

    mem_d      = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = s;

    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
    cnt_d      = cnt_q + 8'(push_ok);
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; cleared so the idle head reads as zero after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign m_if.m_data  = mem_q[rd_ptr_q];
  assign m_if.m_valid = valid;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign capture_cnt  = cnt_q;
endmodule

// File: tb/tb_outport_capture.sv
// tb/tb_outport_capture.sv - directed vector bench for outport_capture
module tb_outport_capture;
  logic       clk;
  logic       reset;
  logic [7:0] outport_in;
  logic       en;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] capture_cnt;

  int checks = 0;
  int errors = 0;

  outport_capture_if #(.DATA_W(8)) m_if ();

  outport_capture #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .outport_in (outport_in),
    .en         (en),
    .m_if       (m_if),
    .level      (level),
    .overflow   (overflow),
    .capture_cnt(capture_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] val;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] el;
    logic       eo;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] rx[$];
  int sums[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [7:0] v, input logic r);
    en = e;
    outport_in = v;
    m_if.m_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic [2:0] el, input logic eo, input logic [7:0] ec);
    check({tag, ".valid"}, 32'(m_if.m_valid), 32'(ev));
    if (ev) check({tag, ".data"}, 32'(m_if.m_data), 32'(ed));
    check({tag, ".level"}, 32'(level), 32'(el));
    check({tag, ".overflow"}, 32'(overflow), 32'(eo));
    check({tag, ".cnt"}, 32'(capture_cnt), 32'(ec));
  endtask

  task automatic do_reset();
    en = 1'b0;
    m_if.m_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    //        en   val    rdy   ev   ed     el    eo   ec
    vecs[0]  = '{1'b1, 8'd0,  1'b1, 1'b0, 8'd0,  3'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'd0,  1'b1, 1'b1, 8'd0,  3'd1, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 8'd0,  1'b1, 1'b0, 8'd0,  3'd0, 1'b0, 8'd1};
    vecs[3]  = '{1'b1, 8'd5,  1'b0, 1'b1, 8'd5,  3'd1, 1'b0, 8'd2};
    vecs[4]  = '{1'b1, 8'd6,  1'b0, 1'b1, 8'd5,  3'd2, 1'b0, 8'd3};
    vecs[5]  = '{1'b1, 8'd7,  1'b0, 1'b1, 8'd5,  3'd3, 1'b0, 8'd4};
    vecs[6]  = '{1'b1, 8'd8,  1'b0, 1'b1, 8'd5,  3'd4, 1'b0, 8'd5};
    vecs[7]  = '{1'b1, 8'd9,  1'b0, 1'b1, 8'd5,  3'd4, 1'b1, 8'd5};
    vecs[8]  = '{1'b1, 8'd10, 1'b0, 1'b1, 8'd5,  3'd4, 1'b1, 8'd5};
    vecs[9]  = '{1'b1, 8'd10, 1'b1, 1'b1, 8'd6,  3'd3, 1'b1, 8'd5};
    vecs[10] = '{1'b1, 8'd10, 1'b1, 1'b1, 8'd7,  3'd2, 1'b1, 8'd5};
    vecs[11] = '{1'b1, 8'd10, 1'b1, 1'b1, 8'd8,  3'd1, 1'b1, 8'd5};
    vecs[12] = '{1'b1, 8'd10, 1'b1, 1'b0, 8'd0,  3'd0, 1'b1, 8'd5};
    vecs[13] = '{1'b1, 8'd10, 1'b1, 1'b0, 8'd0,  3'd0, 1'b1, 8'd5};
    sums = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55};

    outport_in = 8'd0;
    en = 1'b0;
    m_if.m_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 8'd0, 3'd0, 1'b0, 8'd0);
    check("reset.data", 32'(m_if.m_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Prime, backpressure to full with drops, then drain
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].en, vecs[i].val, vecs[i].rdy);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eo, vecs[i].ec);
    end

    // Asynchronous reset with three entries queued
    step(1'b1, 8'd20, 1'b0);
    step(1'b1, 8'd21, 1'b0);
    step(1'b1, 8'd22, 1'b0);
    check_out("pre_rst", 1'b1, 8'd20, 3'd3, 1'b1, 8'd8);
    #2;
    reset = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'd0, 3'd0, 1'b0, 8'd0);
    check("async_rst.data", 32'(m_if.m_data), 32'd0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'd22, 1'b0);
    check_out("restart_idle", 1'b0, 8'd0, 3'd0, 1'b0, 8'd0);
    step(1'b1, 8'd22, 1'b0);
    check_out("restart_prime", 1'b1, 8'd22, 3'd1, 1'b0, 8'd1);

    // Fill to full, then push and pop in the same cycle
    step(1'b1, 8'd23, 1'b0);
    step(1'b1, 8'd24, 1'b0);
    step(1'b1, 8'd25, 1'b0);
    check_out("full", 1'b1, 8'd22, 3'd4, 1'b0, 8'd4);
    step(1'b1, 8'd26, 1'b1);
    check_out("full_pushpop", 1'b1, 8'd23, 3'd4, 1'b0, 8'd5);
    step(1'b1, 8'd26, 1'b1);
    check_out("drain1", 1'b1, 8'd24, 3'd3, 1'b0, 8'd5);
    step(1'b1, 8'd26, 1'b1);
    check_out("drain2", 1'b1, 8'd25, 3'd2, 1'b0, 8'd5);
    step(1'b1, 8'd26, 1'b1);
    check_out("drain3", 1'b1, 8'd26, 3'd1, 1'b0, 8'd5);
    step(1'b1, 8'd26, 1'b1);
    check_out("drain4", 1'b0, 8'd0, 3'd0, 1'b0, 8'd5);

    // Enable toggle with a constant port value: one capture per PRIME
    step(1'b0, 8'h2A, 1'b1);
    check_out("en_off1", 1'b0, 8'd0, 3'd0, 1'b0, 8'd5);
    step(1'b0, 8'h2A, 1'b1);
    check_out("en_off2", 1'b0, 8'd0, 3'd0, 1'b0, 8'd5);
    step(1'b1, 8'h2A, 1'b1);
    check_out("en_on_idle", 1'b0, 8'd0, 3'd0, 1'b0, 8'd5);
    step(1'b1, 8'h2A, 1'b1);
    check_out("en_prime1", 1'b1, 8'h2A, 3'd1, 1'b0, 8'd6);
    step(1'b1, 8'h2A, 1'b1);
    check_out("en_track1", 1'b0, 8'd0, 3'd0, 1'b0, 8'd6);
    step(1'b0, 8'h2A, 1'b1);
    step(1'b0, 8'h2A, 1'b1);
    check_out("en_off3", 1'b0, 8'd0, 3'd0, 1'b0, 8'd6);
    step(1'b1, 8'h2A, 1'b1);
    check_out("en_on_idle2", 1'b0, 8'd0, 3'd0, 1'b0, 8'd6);
    step(1'b1, 8'h2A, 1'b1);
    check_out("en_prime2", 1'b1, 8'h2A, 3'd1, 1'b0, 8'd7);
    step(1'b1, 8'h2A, 1'b1);
    check_out("en_track2", 1'b0, 8'd0, 3'd0, 1'b0, 8'd7);

    // Running-sum sequence, each value held three cycles, free-flowing sink
    do_reset();
    outport_in = 8'd0;
    step(1'b1, 8'd0, 1'b1);
    if (m_if.m_valid) rx.push_back(m_if.m_data);
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, 8'(sums[i]), 1'b1);
        if (m_if.m_valid) rx.push_back(m_if.m_data);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 8'd55, 1'b1);
      if (m_if.m_valid) rx.push_back(m_if.m_data);
    end
    check("sum.count", 32'(rx.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < rx.size()) check($sformatf("sum.val%0d", i), 32'(rx[i]), 32'(sums[i]));
      else check($sformatf("sum.val%0d_missing", i), 32'hFFFF_FFFF, 32'(sums[i]));
    end
    check("sum.cnt", 32'(capture_cnt), 32'd11);
    check("sum.overflow", 32'(overflow), 32'd0);
    check("sum.level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
